rgb_pwm_fader: RTL and testbench
================================

RGB_PWM_FADER -- requirements
Module: rgb_pwm_fader

Interface
REQ-001 The block SHALL have parameter PWM_WIDTH, default 8, giving the PWM counter, brightness and level width W.
REQ-002 The block SHALL have parameter NUM_CHANNELS, default 4, giving the number of valid channel indices, range 1..8.
REQ-003 The block SHALL have parameter FADE_STEP, default 32, giving the level change per frame, range 1..2^W-1.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-005 The block SHALL have port reset, input, 1 bit: reset is synchronous and active-high.
REQ-006 The block SHALL have port curr_channel, input, 3 bits: requested channel index.
REQ-007 The block SHALL have port brightness, input, W bits: target peak level.
REQ-008 The block SHALL have port breathe, input, 1 bit: 1 selects breathing mode, 0 selects steady mode.
REQ-009 The block SHALL have ports led_r, led_g and led_b, outputs, 1 bit each: registered PWM drive.
REQ-010 The block SHALL have port busy, output, 1 bit: high while state is FADE_OUT or FADE_IN.
REQ-011 The block SHALL have port frame_tick, output, 1 bit: high for one cycle while the counter equals 2^W-1.

Function
REQ-012 The W-bit counter SHALL increment every clk and wrap from 2^W-1 to 0, so a frame is 2^W clocks.
REQ-013 The colour SHALL be taken from active_channel as {r,g,b}: 0=100, 1=010, 2=001, 3=110, 4=011, 5=101, 6=111, 7=000; any index >= NUM_CHANNELS SHALL give 000.
REQ-014 Each LED output SHALL be registered as colour bit AND (counter < duty), one clk after the counter value.
REQ-015 Duty 0 SHALL hold all outputs low; duty 2^W-1 SHALL hold the output high for 2^W-1 of 2^W clocks.
REQ-016 The duty register SHALL load only on frame_tick, taking the level computed at that tick, so duty changes take effect at counter 0 and no frame is truncated.
REQ-017 curr_channel, brightness and breathe SHALL be sampled only on frame_tick.
REQ-018 The FSM SHALL have states RUN, FADE_OUT and FADE_IN, and every transition SHALL occur only on frame_tick.
REQ-019 RUN with curr_channel != active_channel SHALL go to FADE_OUT; this has priority over the level update.
REQ-020 RUN with breathe=0 SHALL move level toward brightness by FADE_STEP, saturating exactly at brightness, in either direction.
REQ-021 RUN with breathe=1 SHALL, going up, add FADE_STEP saturating at brightness and then set direction down; going down, subtract FADE_STEP saturating at 0 and then set direction up.
REQ-022 FADE_OUT SHALL subtract FADE_STEP saturating at 0; on the tick at which level is already 0, it SHALL load active_channel from curr_channel and go to FADE_IN.
REQ-023 FADE_IN SHALL add FADE_STEP saturating at brightness and go to RUN with direction down once level equals brightness.
REQ-024 FADE_IN with curr_channel != active_channel SHALL return to FADE_OUT from the current level.
REQ-025 Brightness lowered below level SHALL clamp level to brightness on the next tick in RUN and in FADE_IN.
REQ-026 Level arithmetic SHALL use W+1 bits so that no wrap-around ever occurs.

Reset
REQ-027 While reset is high, the counter, level, duty and active_channel SHALL be 0, and direction SHALL be up.
REQ-028 While reset is high, state SHALL be RUN and led_r, led_g, led_b, busy and frame_tick SHALL be 0.
REQ-029 Reset asserted mid-fade SHALL abort the fade immediately; outputs SHALL be low from the next clk.

Configuration
REQ-030 With macro RGB_PWM_GAMMA_EN defined, duty SHALL load (L*L)>>W, where L is the new level, so that 2^W-1 maps to 2^W-2.
REQ-031 Without RGB_PWM_GAMMA_EN, duty SHALL load L directly; all other behaviour SHALL be identical in both builds.

Verification
REQ-032 With W=8, steady mode, brightness=128, channel 0 and level settled: led_r high for 128 of 256 clks per frame, led_g and led_b held 0.
REQ-033 Brightness stepped 0->100 at FADE_STEP=32: levels over frames 32, 64, 96, 100, then holds at 100.
REQ-034 Channel 0->2 at level 100: FADE_OUT levels 68, 36, 4, 0; next tick sets active_channel=2 and FADE_IN; busy high throughout; led_b ramps.
REQ-035 Breathing, brightness=64: level sequence 32, 64, 32, 0, 32, ... repeating.
REQ-036 curr_channel=5 with NUM_CHANNELS=4: all LEDs stay 0 after the switch; reset mid FADE_IN: all outputs 0 on the next clk and counter restarts at 0.
REQ-037 Gamma build, brightness=255, steady: duty settles at 254 and led high for 254 of 256 clks; level 128 gives duty 64.

Source files
------------

// File: rtl/rgb_pwm_fader.sv
// rgb_pwm_fader: one-hot-ish RGB PWM driver with a frame-synchronous fade engine.
// A free-running W-bit counter defines a 2^W-clock frame. Inputs are sampled and
// the level / duty / channel state only move on frame_tick, so frames are never
// truncated. Optional build macro RGB_PWM_GAMMA_EN squares the level before it
// becomes the duty cycle.
module rgb_pwm_fader #(
  parameter int PWM_WIDTH    = 8,
  parameter int NUM_CHANNELS = 4,
  parameter int FADE_STEP    = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [2:0]           curr_channel,
  input  logic [PWM_WIDTH-1:0] brightness,
  input  logic                 breathe,
  output logic                 led_r,
  output logic                 led_g,
  output logic                 led_b,
  output logic                 busy,
  output logic                 frame_tick
);

  localparam int W = PWM_WIDTH;
  localparam logic [W:0] STEP = (W+1)'(FADE_STEP);

  typedef enum logic [1:0] {RUN, FADE_OUT, FADE_IN} state_t;

  state_t       state, state_nxt;
  logic [W-1:0] cnt;
  logic [W-1:0] duty, duty_nxt;
  // One spare bit so level+STEP never wraps before saturation.
  logic [W:0]   level, level_nxt;
  logic         dir_up, dir_up_nxt;
  logic [2:0]   active_ch, active_ch_nxt;
  logic [2:0]   colour;

  logic [W:0]   bri_ext, up_raw, up_sat, dn_sat, dn_clamp;

  assign frame_tick = (cnt == '1) & ~reset;
  assign busy       = (state != RUN) & ~reset;

  // Saturating step arithmetic shared by all states. Any move clamps to
  // brightness, so lowering brightness below the level snaps down in one tick.
  always_comb begin
    bri_ext  = {1'b0, brightness};
    up_raw   = level + STEP;
    up_sat   = (up_raw > bri_ext) ? bri_ext : up_raw;
    dn_sat   = (level > STEP) ? (level - STEP) : '0;
    dn_clamp = (dn_sat > bri_ext) ? bri_ext : dn_sat;
  end

  // Free-running frame counter.
  always_ff @(posedge clk) begin
    if (reset) cnt <= '0;
    else       cnt <= cnt + 1'b1;
  end

  // Fade FSM and level update; everything holds between frame ticks.
  always_comb begin
    state_nxt     = state;
    level_nxt     = level;
    dir_up_nxt    = dir_up;
    active_ch_nxt = active_ch;
    if (frame_tick) begin
      case (state)
        RUN: begin
          if (curr_channel != active_ch) begin
            // Channel change wins over any level movement this tick.
            state_nxt = FADE_OUT;
          end else if (breathe && !dir_up) begin
            level_nxt = dn_clamp;
            if (dn_clamp == '0) dir_up_nxt = 1'b1;
          end else begin
            // Steady mode and breathing-up share the saturating climb.
            level_nxt = up_sat;
            if (breathe && up_sat == bri_ext) dir_up_nxt = 1'b0;
          end
        end
        FADE_OUT: begin
          if (level == '0) begin
            active_ch_nxt = curr_channel;
            state_nxt     = FADE_IN;
          end else begin
            level_nxt = dn_sat;
          end
        end
        FADE_IN: begin
          if (curr_channel != active_ch) begin
            state_nxt = FADE_OUT;
          end else begin
            level_nxt = up_sat;
            if (up_sat == bri_ext) begin
              state_nxt  = RUN;
              dir_up_nxt = 1'b0;
            end
          end
        end
        default: state_nxt = RUN;
      endcase
    end
  end

`ifdef RGB_PWM_GAMMA_EN
  // Square-law duty so perceived brightness tracks the level more evenly.
  logic [2*W-1:0] sq;
  always_comb begin
    sq       = level_nxt[W-1:0] * level_nxt[W-1:0];
    duty_nxt = W'(sq >> W);
  end
`else
  // Linear duty: the level is the duty cycle.
  always_comb duty_nxt = level_nxt[W-1:0];
`endif

  // State registers; duty only loads at the frame boundary.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= RUN;
      level     <= '0;
      dir_up    <= 1'b1;
      active_ch <= '0;
      duty      <= '0;
    end else begin
      state     <= state_nxt;
      level     <= level_nxt;
      dir_up    <= dir_up_nxt;
      active_ch <= active_ch_nxt;
      if (frame_tick) duty <= duty_nxt;
    end
  end

  // Channel index to {r,g,b}; indices past NUM_CHANNELS are dark.
  always_comb begin
    colour = 3'b000;
    if ({29'b0, active_ch} < NUM_CHANNELS) begin
      case (active_ch)
        3'd0:    colour = 3'b100;
        3'd1:    colour = 3'b010;
        3'd2:    colour = 3'b001;
        3'd3:    colour = 3'b110;
        3'd4:    colour = 3'b011;
        3'd5:    colour = 3'b101;
        3'd6:    colour = 3'b111;
        default: colour = 3'b000;
      endcase
    end
  end

  // Registered PWM compare, one clock behind the counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      led_r <= 1'b0;
      led_g <= 1'b0;
      led_b <= 1'b0;
    end else begin
      led_r <= colour[2] & (cnt < duty);
      led_g <= colour[1] & (cnt < duty);
      led_b <= colour[0] & (cnt < duty);
    end
  end

endmodule

// File: tb/tb_rgb_pwm_fader.sv
// tb_rgb_pwm_fader: directed frame-level scenarios plus randomized input churn,
// checked cycle by cycle against a frame-level behavioural model.
module tb_rgb_pwm_fader;
  localparam int W    = 8;
  localparam int NCH  = 4;
  localparam int STEP = 32;
  localparam int MAXC = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [2:0]   curr_channel = 3'd0;
  logic [W-1:0] brightness = '0;
  logic         breathe = 1'b0;
  logic         led_r, led_g, led_b, busy, frame_tick;

  rgb_pwm_fader #(.PWM_WIDTH(W), .NUM_CHANNELS(NCH), .FADE_STEP(STEP)) dut (
    .clk(clk), .reset(reset), .curr_channel(curr_channel), .brightness(brightness),
    .breathe(breathe), .led_r(led_r), .led_g(led_g), .led_b(led_b),
    .busy(busy), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Model state: mode 0=steady/breathing, 1=fading out, 2=fading in.
  int m_cnt = 0, m_lv = 0, m_duty = 0, m_act = 0, m_mode = 0, m_up = 1, m_led = 0;
  // Per-frame high counts, one entry per complete PWM frame.
  int q_r[$], q_g[$], q_b[$];
  int acc_r = 0, acc_g = 0, acc_b = 0, started = 0;

  function automatic int colour(input int a);
    int t[8] = '{4, 2, 1, 6, 3, 5, 7, 0};
    return (a < NCH) ? t[a] : 0;
  endfunction

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  // One frame-boundary decision from the current inputs.
  task automatic frame_update();
    int ch, bri;
    ch  = int'(curr_channel);
    bri = int'(brightness);
    case (m_mode)
      0: begin
        if (ch != m_act) m_mode = 1;
        else if (breathe && !m_up) begin
          m_lv = imin((m_lv > STEP) ? m_lv - STEP : 0, bri);
          if (m_lv == 0) m_up = 1;
        end else begin
          m_lv = imin(m_lv + STEP, bri);
          if (breathe && m_lv == bri) m_up = 0;
        end
      end
      1: begin
        if (m_lv == 0) begin m_act = ch; m_mode = 2; end
        else m_lv = (m_lv > STEP) ? m_lv - STEP : 0;
      end
      default: begin
        if (ch != m_act) m_mode = 1;
        else begin
          m_lv = imin(m_lv + STEP, bri);
          if (m_lv == bri) begin m_mode = 0; m_up = 0; end
        end
      end
    endcase
`ifdef RGB_PWM_GAMMA_EN
    m_duty = (m_lv * m_lv) >> W;
`else
    m_duty = m_lv;
`endif
  endtask

  // Predict the coming rising edge, then compare at the falling edge.
  task automatic step();
    if (reset) begin
      m_cnt = 0; m_lv = 0; m_duty = 0; m_act = 0; m_mode = 0; m_up = 1; m_led = 0;
      started = 0;
    end else begin
      m_led = (m_cnt < m_duty) ? colour(m_act) : 0;
      if (m_cnt == MAXC) frame_update();
      m_cnt = (m_cnt + 1) % (MAXC + 1);
    end
    @(negedge clk);
    chk("led_rgb", {29'b0, led_r, led_g, led_b}, m_led);
    chk("frame_tick", {31'b0, frame_tick}, {31'b0, (m_cnt == MAXC) && !reset});
    chk("busy", {31'b0, busy}, {31'b0, (m_mode != 0) && !reset});
    if (!reset) begin
      if (m_cnt == 1) begin started = 1; acc_r = 0; acc_g = 0; acc_b = 0; end
      acc_r += led_r; acc_g += led_g; acc_b += led_b;
      if (m_cnt == 0 && started != 0) begin
        q_r.push_back(acc_r); q_g.push_back(acc_g); q_b.push_back(acc_b);
      end
    end
  endtask

  task automatic clearq();
    q_r.delete(); q_g.delete(); q_b.delete();
  endtask

  task automatic frames(input int n);
    int target, guard;
    target = q_r.size() + n;
    guard  = 0;
    while (q_r.size() < target && guard < (n + 2) * (MAXC + 1)) begin
      step();
      guard++;
    end
    if (q_r.size() < target) chk("frame_timeout", q_r.size(), target);
  endtask

  initial begin
    int exp_q[$];
    int n;

    // Reset held: all outputs low.
    reset = 1'b1;
    repeat (4) step();
    chk("rst_leds", {29'b0, led_r, led_g, led_b}, 0);

    // Steady ramp on channel 0.
    curr_channel = 3'd0; brightness = 8'd100; breathe = 1'b0;
    reset = 1'b0;
    clearq();
    frames(6);
`ifndef RGB_PWM_GAMMA_EN
    exp_q = '{0, 32, 64, 96, 100, 100};
    foreach (exp_q[i]) chk($sformatf("ramp_r%0d", i), q_r[i], exp_q[i]);
    chk("ramp_g", q_g[5], 0);

    // Half duty on red only.
    brightness = 8'd128;
    frames(4);
    chk("half_r", q_r[q_r.size()-1], 128);
    chk("half_g", q_g[q_g.size()-1], 0);
    chk("half_b", q_b[q_b.size()-1], 0);
    brightness = 8'd100;
    frames(3);
    chk("clamp_r", q_r[q_r.size()-1], 100);

    // Cross-fade red to blue.
    clearq();
    curr_channel = 3'd2;
    frames(11);
    exp_q = '{100, 100, 68, 36, 4, 0};
    foreach (exp_q[i]) chk($sformatf("xf_r%0d", i), q_r[i], exp_q[i]);
    exp_q = '{0, 32, 64, 96, 100};
    foreach (exp_q[i]) chk($sformatf("xf_b%0d", i), q_b[i+6], exp_q[i]);

    // Breathing on blue.
    clearq();
    brightness = 8'd64; breathe = 1'b1;
    frames(8);
    exp_q = '{64, 32, 0, 32, 64, 32, 0};
    foreach (exp_q[i]) chk($sformatf("brth_b%0d", i), q_b[i+1], exp_q[i]);
`else
    // Square-law duty at full and half level.
    brightness = 8'd255;
    frames(12);
    chk("gam_full", q_r[q_r.size()-1], 254);
    brightness = 8'd128;
    frames(3);
    chk("gam_half", q_r[q_r.size()-1], 64);
`endif

    // Out-of-range channel stays dark; reset lands mid fade-in.
    breathe = 1'b0; brightness = 8'd200; curr_channel = 3'd5;
    n = 0;
    while (!(m_mode == 2 && m_lv >= 64) && n < 20 * (MAXC + 1)) begin step(); n++; end
    chk("fadein_reached", {31'b0, m_mode == 2}, 1);
    chk("dark_ch5", {29'b0, led_r, led_g, led_b}, 0);
    repeat (100) step();
    reset = 1'b1;
    step();
    chk("rst_mid_leds", {29'b0, led_r, led_g, led_b}, 0);
    chk("rst_mid_busy", {31'b0, busy}, 0);
    reset = 1'b0;
    n = 0;
    step();
    while (!frame_tick && n < 400) begin step(); n++; end
    chk("restart_len", n, MAXC - 1);

    // Random input churn, including sparse resets.
    for (int c = 0; c < 30000; c++) begin
      if ($urandom_range(0, 299) == 0) begin
        if ($urandom_range(0, 3) == 0) curr_channel = 3'($urandom_range(0, 7));
        brightness = W'($urandom_range(0, MAXC));
        breathe    = 1'($urandom_range(0, 1));
      end
      reset = ($urandom_range(0, 7999) == 0);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
